// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the stage-1 alert generator and the downstream twiddle-select controller.
// half_sel encodings must stay identical on both ends.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HALF_A = 2'd1,
    HALF_B = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  localparam logic SEL_1234 = 1'b0;
  localparam logic SEL_5678 = 1'b1;

  // Counter width for a limit n; a limit of 1 still needs a 1-bit register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrl_fft_in_alert.sv
// Beat acceptor that pulses alert_out once per half-block and inserts a flush gap after each frame.
// All outputs registered (1-cycle latency); din_ready drops only during the post-frame flush.
module ctrl_fft_in_alert
  import fft_ctrl_pkg::*;
#(
  parameter int  HALF_BEATS   = 4,
  parameter int  FRAME_HALVES = 8,
  parameter int  FLUSH_CYC    = 3,
  localparam int BW           = cnt_w(HALF_BEATS),
  localparam int HW           = cnt_w(FRAME_HALVES),
  localparam int FW           = cnt_w(FLUSH_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          alert_out,
  output logic          half_sel,
  output logic [BW-1:0] beat_idx,
  output logic          frame_last,
  output logic          busy
);

  localparam logic [BW-1:0] BEAT_LAST  = BW'(HALF_BEATS - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(FRAME_HALVES - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [HW-1:0]   half_cnt_q, half_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            din_ready_q, din_ready_d;
  logic            alert_q, alert_d;
  logic            half_sel_q, half_sel_d;
  logic [BW-1:0]   beat_idx_q, beat_idx_d;
  logic            frame_last_q, frame_last_d;
  logic            busy_q, busy_d;
  logic            accept;

  assign accept = din_valid & din_ready_q;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    half_cnt_d   = half_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    half_sel_d   = half_sel_q;
    beat_idx_d   = beat_idx_q;
    alert_d      = 1'b0;
    frame_last_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          alert_d    = 1'b1;
          half_sel_d = SEL_1234;
          beat_idx_d = '0;
          beat_cnt_d = BW'(1);
          half_cnt_d = '0;
          state_d    = HALF_A;
        end
      end
      HALF_A, HALF_B: begin
        if (accept) begin
          beat_idx_d = beat_cnt_q;
          // beat_cnt of zero here means the previous half-block has closed.
          if (beat_cnt_q == '0) begin
            alert_d    = 1'b1;
            half_sel_d = ~half_sel_q;
            state_d    = (state_q == HALF_A) ? HALF_B : HALF_A;
          end
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            if (half_cnt_q == HALF_LAST) begin
              half_cnt_d   = '0;
              frame_last_d = 1'b1;
              state_d      = FLUSH;
            end else begin
              half_cnt_d = half_cnt_q + HW'(1);
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = '0;
          half_sel_d  = SEL_1234;
          state_d     = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Derived from next state so ready/busy track the state register with no valid->ready path.
    din_ready_d = (state_d != FLUSH);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      half_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      din_ready_q  <= 1'b0;
      alert_q      <= 1'b0;
      half_sel_q   <= SEL_1234;
      beat_idx_q   <= '0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      half_cnt_q   <= half_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      din_ready_q  <= din_ready_d;
      alert_q      <= alert_d;
      half_sel_q   <= half_sel_d;
      beat_idx_q   <= beat_idx_d;
      frame_last_q <= frame_last_d;
      busy_q       <= busy_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign alert_out  = alert_q;
  assign half_sel   = half_sel_q;
  assign beat_idx   = beat_idx_q;
  assign frame_last = frame_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ctrl_fft_in_alert.sv
// Directed bench for ctrl_fft_in_alert: default instance plus a small-parameter instance,
// with a downstream select model driven by alert_out.
module tb_ctrl_fft_in_alert;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid, din_valid2;
  logic       din_ready, alert_out, half_sel, frame_last, busy;
  logic [1:0] beat_idx;
  logic       din_ready2, alert_out2, half_sel2, frame_last2, busy2;
  logic [0:0] beat_idx2;

  int n_chk  = 0;
  int n_pass = 0;

  // Downstream twiddle-select model: each enable pulse consumes the pending select and flips it.
  logic ds_nxt, ds_held, mul_val_sel;
  assign mul_val_sel = alert_out ? ds_nxt : ds_held;
  always @(posedge clk) begin
    if (rst) begin
      ds_nxt  <= 1'b0;
      ds_held <= 1'b0;
    end else if (alert_out) begin
      ds_held <= ds_nxt;
      ds_nxt  <= ~ds_nxt;
    end
  end

  always #5 clk = ~clk;

  ctrl_fft_in_alert dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
    .alert_out(alert_out), .half_sel(half_sel), .beat_idx(beat_idx),
    .frame_last(frame_last), .busy(busy)
  );

  ctrl_fft_in_alert #(.HALF_BEATS(2), .FRAME_HALVES(2), .FLUSH_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid2), .din_ready(din_ready2),
    .alert_out(alert_out2), .half_sel(half_sel2), .beat_idx(beat_idx2),
    .frame_last(frame_last2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din_valid2 = 1'b0;
    tick(); tick();
    chk("rst_din_ready", int'(din_ready), 0);
    chk("rst_alert", int'(alert_out), 0);
    chk("rst_half_sel", int'(half_sel), 0);
    chk("rst_beat_idx", int'(beat_idx), 0);
    chk("rst_frame_last", int'(frame_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_din_ready2", int'(din_ready2), 0);

    rst = 1'b0;
    tick();
    chk("idle_din_ready", int'(din_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // Frame of 32 back-to-back beats; valid stays high through the flush.
    din_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("f1_alert_%0d", i), int'(alert_out), (i % 4 == 0) ? 1 : 0);
      chk($sformatf("f1_half_sel_%0d", i), int'(half_sel), (i / 4) % 2);
      chk($sformatf("f1_beat_idx_%0d", i), int'(beat_idx), i % 4);
      chk($sformatf("f1_frame_last_%0d", i), int'(frame_last), (i == 31) ? 1 : 0);
      chk($sformatf("f1_busy_%0d", i), int'(busy), 1);
      chk($sformatf("f1_din_ready_%0d", i), int'(din_ready), (i == 31) ? 0 : 1);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("flush_din_ready_%0d", i), int'(din_ready), 0);
      chk($sformatf("flush_alert_%0d", i), int'(alert_out), 0);
      chk($sformatf("flush_frame_last_%0d", i), int'(frame_last), 0);
      chk($sformatf("flush_busy_%0d", i), int'(busy), 1);
    end
    tick();
    chk("flush_exit_din_ready", int'(din_ready), 1);
    chk("flush_exit_alert", int'(alert_out), 0);
    chk("flush_exit_half_sel", int'(half_sel), 0);
    chk("flush_exit_busy", int'(busy), 0);

    // Second frame: first beat, then a stall after beat 2.
    tick();
    chk("f2_b1_alert", int'(alert_out), 1);
    chk("f2_b1_half_sel", int'(half_sel), 0);
    chk("f2_b1_beat_idx", int'(beat_idx), 0);
    tick();
    chk("f2_b2_alert", int'(alert_out), 0);
    chk("f2_b2_beat_idx", int'(beat_idx), 1);
    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_beat_idx_%0d", i), int'(beat_idx), 1);
      chk($sformatf("stall_half_sel_%0d", i), int'(half_sel), 0);
      chk($sformatf("stall_alert_%0d", i), int'(alert_out), 0);
    end
    din_valid = 1'b1;
    tick();
    chk("f2_b3_beat_idx", int'(beat_idx), 2);
    chk("f2_b3_alert", int'(alert_out), 0);
    tick();
    chk("f2_b4_beat_idx", int'(beat_idx), 3);
    chk("f2_b4_alert", int'(alert_out), 0);
    tick();
    chk("f2_b5_alert", int'(alert_out), 1);
    chk("f2_b5_half_sel", int'(half_sel), 1);
    chk("f2_b5_beat_idx", int'(beat_idx), 0);
    for (int i = 6; i <= 10; i++) tick();
    chk("f2_b10_beat_idx", int'(beat_idx), 1);
    chk("f2_b10_half_sel", int'(half_sel), 0);

    // Reset mid-frame discards the partial frame.
    rst = 1'b1;
    tick();
    chk("mid_rst_din_ready", int'(din_ready), 0);
    chk("mid_rst_alert", int'(alert_out), 0);
    chk("mid_rst_half_sel", int'(half_sel), 0);
    chk("mid_rst_beat_idx", int'(beat_idx), 0);
    chk("mid_rst_frame_last", int'(frame_last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    din_valid = 1'b0;
    tick();
    chk("post_rst_din_ready", int'(din_ready), 1);
    chk("post_rst_frame_last", int'(frame_last), 0);

    // Fresh frame in lockstep with the downstream select model.
    din_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("ls_sel_%0d", i), int'(half_sel), int'(mul_val_sel));
      if (i == 0) begin
        chk("ls_b1_alert", int'(alert_out), 1);
        chk("ls_b1_half_sel", int'(half_sel), 0);
        chk("ls_b1_beat_idx", int'(beat_idx), 0);
      end
    end
    chk("ls_frame_last", int'(frame_last), 1);
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("ls_flush_done_ready", int'(din_ready), 1);

    // Small-parameter instance: 2 beats/half, 2 halves, 1 flush cycle.
    din_valid2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("p2_alert_%0d", k), int'(alert_out2), (k == 1 || k == 3) ? 1 : 0);
      chk($sformatf("p2_half_sel_%0d", k), int'(half_sel2), (k >= 3) ? 1 : 0);
      chk($sformatf("p2_beat_idx_%0d", k), int'(beat_idx2), (k - 1) % 2);
      chk($sformatf("p2_frame_last_%0d", k), int'(frame_last2), (k == 4) ? 1 : 0);
      chk($sformatf("p2_din_ready_%0d", k), int'(din_ready2), (k == 4) ? 0 : 1);
    end
    tick();
    chk("p2_flush_exit_ready", int'(din_ready2), 1);
    chk("p2_flush_exit_alert", int'(alert_out2), 0);
    chk("p2_flush_exit_busy", int'(busy2), 0);
    din_valid2 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
